// File: rtl/smc_wr_strobe_gen19.sv
// Registered write-strobe generator for the static memory controller.
// Sequences setup, pulse and hold phases and drives the active-low byte enables and write strobe.
module smc_wr_strobe_gen19 #(
  parameter int unsigned NUM_BE = 4,
  parameter int unsigned CNT_W  = 4
) (
  input  logic              sys_clk19,
  input  logic              n_sys_reset19,
  input  logic              wr_req,
  input  logic [NUM_BE-1:0] wr_be,
  input  logic [CNT_W-1:0]  cfg_setup,
  input  logic [CNT_W-1:0]  cfg_pulse,
  input  logic [CNT_W-1:0]  cfg_hold,
  input  logic              cfg_full,
  input  logic              abort,
  output logic              wr_ack,
  output logic              busy,
  output logic              done,
  output logic [NUM_BE-1:0] smc_n_we,
  output logic              smc_n_wr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_BE-1:0] be_q;
  logic              full_q;
  logic [CNT_W-1:0]  pulse_q;
  logic [CNT_W-1:0]  hold_q;
  logic              done_pend_q;
  logic              accept_c;
  logic              end_c;
  logic              strobe_on_c;

  // Counter reload for the strobe phase; a zero pulse count still gives one cycle.
  function automatic logic [CNT_W-1:0] pulse_load(input logic [CNT_W-1:0] p);
    pulse_load = (p == '0) ? '0 : p - CNT_W'(1);
  endfunction

  // State register.
  always_ff @(posedge sys_clk19 or negedge n_sys_reset19) begin
    if (!n_sys_reset19) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter holds the remaining cycles minus one in each phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    accept_c = 1'b0;
    end_c    = 1'b0;
    case (state_q)
      IDLE: begin
        if (wr_req) begin
          accept_c = 1'b1;
          if (cfg_setup != '0) begin
            state_d = SETUP;
            cnt_d   = cfg_setup - CNT_W'(1);
          end else begin
            state_d = STROBE;
            cnt_d   = pulse_load(cfg_pulse);
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = STROBE;
          cnt_d   = pulse_load(pulse_q);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      STROBE: begin
        if (cnt_q == '0) begin
          if (hold_q != '0) begin
            state_d = HOLD;
            cnt_d   = hold_q - CNT_W'(1);
          end else begin
            state_d = IDLE;
            end_c   = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          end_c   = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = IDLE;
      cnt_d   = '0;
      end_c   = 1'b0;
    end
  end

  // Pins are re-timed from the current state, so STROBE is always followed by a high cycle.
  assign strobe_on_c = (state_q == STROBE) && !abort;

  // Access parameters frozen at acceptance.
  always_ff @(posedge sys_clk19 or negedge n_sys_reset19) begin
    if (!n_sys_reset19) begin
      be_q    <= '0;
      full_q  <= 1'b0;
      pulse_q <= '0;
      hold_q  <= '0;
    end else if (accept_c) begin
      be_q    <= wr_be;
      full_q  <= cfg_full;
      pulse_q <= cfg_pulse;
      hold_q  <= cfg_hold;
    end
  end

  // Registered handshake and pin outputs.
  always_ff @(posedge sys_clk19 or negedge n_sys_reset19) begin
    if (!n_sys_reset19) begin
      wr_ack      <= 1'b0;
      busy        <= 1'b0;
      done_pend_q <= 1'b0;
      done        <= 1'b0;
      smc_n_we    <= '1;
      smc_n_wr    <= 1'b1;
    end else begin
      wr_ack      <= accept_c;
      busy        <= (state_d != IDLE);
      done_pend_q <= end_c;
      done        <= done_pend_q;
      smc_n_we    <= strobe_on_c ? ~(be_q & {NUM_BE{full_q}}) : '1;
      smc_n_wr    <= strobe_on_c ? ~full_q : 1'b1;
    end
  end

endmodule

// File: tb/tb_smc_wr_strobe_gen19.sv
// Scoreboard bench for smc_wr_strobe_gen19: per-cycle expected outputs are planned from
// a timing model when a request is driven, queued, and popped against the DUT each cycle.
module tb_smc_wr_strobe_gen19;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_req;
  logic [3:0] wr_be;
  logic [3:0] cfg_setup;
  logic [3:0] cfg_pulse;
  logic [3:0] cfg_hold;
  logic       cfg_full;
  logic       abort;
  logic       wr_ack;
  logic       busy;
  logic       done;
  logic [3:0] smc_n_we;
  logic       smc_n_wr;

  typedef struct packed {
    logic       ack;
    logic       busy;
    logic       done;
    logic [3:0] we_n;
    logic       wr_n;
  } obs_t;

  obs_t plan_a [0:63];
  obs_t exp_q  [$];
  obs_t cur;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  assign cur = {wr_ack, busy, done, smc_n_we, smc_n_wr};

  smc_wr_strobe_gen19 #(.NUM_BE(4), .CNT_W(4)) dut (
    .sys_clk19    (clk),
    .n_sys_reset19(rst_n),
    .wr_req       (wr_req),
    .wr_be        (wr_be),
    .cfg_setup    (cfg_setup),
    .cfg_pulse    (cfg_pulse),
    .cfg_hold     (cfg_hold),
    .cfg_full     (cfg_full),
    .abort        (abort),
    .wr_ack       (wr_ack),
    .busy         (busy),
    .done         (done),
    .smc_n_we     (smc_n_we),
    .smc_n_wr     (smc_n_wr)
  );

  function automatic obs_t idle_obs();
    idle_obs = {1'b0, 1'b0, 1'b0, 4'hf, 1'b1};
  endfunction

  function automatic void clear_plan();
    for (int i = 0; i < 64; i++) plan_a[i] = idle_obs();
  endfunction

  // Timing model: accept edge k, strobes low from k+1+s for max(p,1), done at k+T+1.
  function automatic int plan(input int k, input int s, input int p, input int h,
                              input logic [3:0] be, input logic full);
    int pe;
    int t;
    pe = (p == 0) ? 1 : p;
    t  = s + pe + h;
    for (int c = 0; c <= t + 1; c++) begin
      if (c == 0) plan_a[k+c].ack = 1'b1;
      if (c < t) plan_a[k+c].busy = 1'b1;
      if (full && (c >= s + 1) && (c < s + pe + 1)) begin
        plan_a[k+c].we_n = plan_a[k+c].we_n & ~be;
        plan_a[k+c].wr_n = 1'b0;
      end
      if (c == t + 1) plan_a[k+c].done = 1'b1;
    end
    return k + t + 1;
  endfunction

  task automatic load_queue(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(plan_a[i]);
  endtask

  task automatic set_cfg(input int s, input int p, input int h,
                         input logic [3:0] be, input logic full);
    cfg_setup = 4'(s);
    cfg_pulse = 4'(p);
    cfg_hold  = 4'(h);
    wr_be     = be;
    cfg_full  = full;
  endtask

  task automatic test_reset();
    rst_n  = 1'b1;
    wr_req = 1'b0;
    abort  = 1'b0;
    set_cfg(0, 0, 0, 4'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cur !== idle_obs()) begin
      failures++;
      $display("FAIL reset_value got=%b exp=%b", cur, idle_obs());
    end
    @(negedge clk) rst_n = 1'b1;
    clear_plan();
    load_queue(3);
    for (int i = 0; i < 3; i++) begin
      obs_t e;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (cur !== e) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%b exp=%b", i, cur, e);
      end
    end
  endtask

  task automatic test_reset_mid_strobe();
    int k;
    clear_plan();
    set_cfg(2, 3, 1, 4'b1010, 1'b1);
    wr_req = 1'b1;
    k = plan(0, 2, 3, 1, 4'b1010, 1'b1);
    load_queue(5);
    for (int i = 0; i < 5; i++) begin
      obs_t e;
      if (i == 1) wr_req = 1'b0;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (cur !== e) begin
        failures++;
        $display("FAIL rst_mid_pre cyc=%0d got=%b exp=%b", i, cur, e);
      end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cur !== idle_obs()) begin
      failures++;
      $display("FAIL rst_mid_async got=%b exp=%b", cur, idle_obs());
    end
    @(negedge clk) rst_n = 1'b1;
    clear_plan();
    load_queue(8);
    for (int i = 0; i < 8; i++) begin
      obs_t e;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (cur !== e) begin
        failures++;
        $display("FAIL rst_mid_post cyc=%0d got=%b exp=%b", i, cur, e);
      end
    end
  endtask

  task automatic test_basic();
    int k;
    clear_plan();
    set_cfg(2, 3, 1, 4'b0110, 1'b1);
    wr_req = 1'b1;
    k = plan(0, 2, 3, 1, 4'b0110, 1'b1);
    load_queue(10);
    for (int i = 0; i < 10; i++) begin
      obs_t e;
      if (i == 1) begin
        wr_req = 1'b0;
        set_cfg(9, 0, 7, 4'b1111, 1'b0);
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (cur !== e) begin
        failures++;
        $display("FAIL basic cyc=%0d got=%b exp=%b", i, cur, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    int k;
    clear_plan();
    set_cfg(0, 0, 0, 4'b1100, 1'b1);
    wr_req = 1'b1;
    k = plan(0, 0, 0, 0, 4'b1100, 1'b1);
    k = plan(k, 0, 0, 0, 4'b1100, 1'b1);
    k = plan(k, 0, 0, 0, 4'b1100, 1'b1);
    load_queue(9);
    for (int i = 0; i < 9; i++) begin
      obs_t e;
      if (i == 5) wr_req = 1'b0;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (cur !== e) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got=%b exp=%b", i, cur, e);
      end
    end
  endtask

  task automatic test_abort();
    int k;
    clear_plan();
    set_cfg(2, 2, 3, 4'b0011, 1'b1);
    wr_req = 1'b1;
    k = plan(0, 2, 2, 3, 4'b0011, 1'b1);
    for (int i = 5; i < 64; i++) plan_a[i] = idle_obs();
    k = plan(6, 0, 1, 0, 4'b1111, 1'b1);
    load_queue(12);
    for (int i = 0; i < 12; i++) begin
      obs_t e;
      if (i == 1) begin
        wr_req = 1'b0;
        set_cfg(0, 1, 0, 4'b1111, 1'b1);
      end
      if (i == 2) wr_req = 1'b1;
      if (i == 5) abort = 1'b1;
      if (i == 7) begin
        abort  = 1'b0;
        wr_req = 1'b0;
      end
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (cur !== e) begin
        failures++;
        $display("FAIL abort cyc=%0d got=%b exp=%b", i, cur, e);
      end
    end
  endtask

  task automatic test_dummy();
    int k;
    clear_plan();
    set_cfg(1, 2, 1, 4'b1111, 1'b0);
    wr_req = 1'b1;
    k = plan(0, 1, 2, 1, 4'b1111, 1'b0);
    k = plan(k, 0, 2, 0, 4'b0000, 1'b1);
    load_queue(11);
    for (int i = 0; i < 11; i++) begin
      obs_t e;
      if (i == 1) set_cfg(0, 2, 0, 4'b0000, 1'b1);
      if (i == 6) wr_req = 1'b0;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (cur !== e) begin
        failures++;
        $display("FAIL dummy_empty cyc=%0d got=%b exp=%b", i, cur, e);
      end
    end
  endtask

  task automatic test_max();
    int k;
    clear_plan();
    set_cfg(15, 15, 15, 4'b1001, 1'b1);
    wr_req = 1'b1;
    k = plan(0, 15, 15, 15, 4'b1001, 1'b1);
    load_queue(50);
    for (int i = 0; i < 50; i++) begin
      obs_t e;
      if (i == 1) wr_req = 1'b0;
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if (cur !== e) begin
        failures++;
        $display("FAIL max_counts cyc=%0d got=%b exp=%b", i, cur, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_strobe();
    test_basic();
    test_back_to_back();
    test_abort();
    test_dummy();
    test_max();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
